// File: rtl/caf_foas_scheduler.sv
// caf_foas_scheduler: sequences one CAF run.
//   IDLE -> LOAD (present one frequency offset per slice) -> STREAM (gate exactly
//   `length` samples into the caf block) -> COLLECT (reduce per-slice peaks to the
//   global peak) -> DONE (one-cycle done pulse) -> IDLE.
// Optional feature: define CAF_SCHED_TIMEOUT_EN to enable the COLLECT watchdog.
//   Without it, COLLECT waits indefinitely and timeout_err stays 0.
module caf_foas_scheduler #(
    parameter int unsigned phase_bits          = 10,
    parameter int unsigned foas                = 3,
    parameter int unsigned foas_counter_bits   = 3,
    parameter int unsigned length              = 5,
    parameter int unsigned length_counter_bits = 3,
    parameter int unsigned out_max_bits        = 64,
    parameter int unsigned timeout_cycles      = 256
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [phase_bits-1:0]          freq_delta,
    output logic                           busy,
    output logic [phase_bits-1:0]          freq_step,
    output logic                           freq_step_valid,
    output logic                           neg_shift,
    input  logic                           freq_step_ready,
    input  logic                           smp_tvalid,
    output logic                           smp_tready,
    output logic                           caf_tvalid,
    input  logic                           caf_tready,
    input  logic                           res_tvalid,
    input  logic [foas_counter_bits-1:0]   res_foa,
    input  logic [out_max_bits-1:0]        res_max,
    input  logic [length_counter_bits-1:0] res_index,
    output logic                           res_tready,
    output logic [out_max_bits-1:0]        best_max,
    output logic [length_counter_bits-1:0] best_index,
    output logic [foas_counter_bits-1:0]   best_foa,
    output logic                           done,
    output logic                           timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_COLLECT,
        S_DONE
    } state_t;

    // Slice index of the zero offset; slices below it get negative offsets.
    localparam logic [foas_counter_bits-1:0]   K_CENTER = foas_counter_bits'(foas / 2);
    localparam logic [foas_counter_bits-1:0]   K_LAST   = foas_counter_bits'(foas - 1);
    localparam logic [length_counter_bits-1:0] N_LAST   = length_counter_bits'(length - 1);
    localparam int unsigned                    WD_BITS  = $clog2(timeout_cycles + 1);
    localparam logic [WD_BITS-1:0]             WD_LAST  = WD_BITS'(timeout_cycles - 1);

`ifdef CAF_SCHED_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    state_t                         state_q, state_d;
    logic [phase_bits-1:0]          delta_q, delta_d;
    logic [foas_counter_bits-1:0]   k_q, k_d;
    logic [foas_counter_bits-1:0]   r_q, r_d;
    logic [length_counter_bits-1:0] n_q, n_d;
    logic [out_max_bits-1:0]        best_max_q, best_max_d;
    logic [length_counter_bits-1:0] best_index_q, best_index_d;
    logic [foas_counter_bits-1:0]   best_foa_q, best_foa_d;
    logic                           timeout_err_q, timeout_err_d;
    logic [phase_bits-1:0]          step_mag;
    logic [WD_BITS-1:0]             wd_q;
    logic                           wd_hit;

`ifdef CAF_SCHED_TIMEOUT_EN
    logic [WD_BITS-1:0] wd_d;

    // Watchdog: counts COLLECT cycles since the last result beat.
    always_comb begin
        wd_d = '0;
        if (state_q == S_COLLECT && !res_tvalid) begin
            wd_d = wd_q + 1'b1;
        end
    end

    // Watchdog register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign wd_q = '0;
`endif

    assign wd_hit = TIMEOUT_EN && (state_q == S_COLLECT) && !res_tvalid && (wd_q == WD_LAST);

    assign busy        = (state_q != S_IDLE);
    assign best_max    = best_max_q;
    assign best_index  = best_index_q;
    assign best_foa    = best_foa_q;
    assign timeout_err = timeout_err_q;

    // Next-state, counters, peak reduction and handshake outputs.
    always_comb begin
        state_d         = state_q;
        delta_d         = delta_q;
        k_d             = k_q;
        r_d             = r_q;
        n_d             = n_q;
        best_max_d      = best_max_q;
        best_index_d    = best_index_q;
        best_foa_d      = best_foa_q;
        timeout_err_d   = timeout_err_q;
        step_mag        = '0;
        freq_step       = '0;
        freq_step_valid = 1'b0;
        neg_shift       = 1'b0;
        smp_tready      = 1'b0;
        caf_tvalid      = 1'b0;
        res_tready      = 1'b0;
        done            = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_LOAD;
                    delta_d       = freq_delta;
                    k_d           = '0;
                    best_max_d    = '0;
                    best_index_d  = '0;
                    best_foa_d    = '0;
                    timeout_err_d = 1'b0;
                end
            end

            S_LOAD: begin
                freq_step_valid = 1'b1;
                if (k_q < K_CENTER) begin
                    step_mag  = phase_bits'(K_CENTER - k_q);
                    neg_shift = 1'b1;
                end else begin
                    step_mag  = phase_bits'(k_q - K_CENTER);
                end
                freq_step = step_mag * delta_q;
                if (freq_step_ready) begin
                    k_d = k_q + 1'b1;
                    if (k_q == K_LAST) begin
                        state_d = S_STREAM;
                        n_d     = '0;
                    end
                end
            end

            S_STREAM: begin
                smp_tready = caf_tready;
                caf_tvalid = smp_tvalid;
                if (smp_tvalid && caf_tready) begin
                    n_d = n_q + 1'b1;
                    if (n_q == N_LAST) begin
                        state_d = S_COLLECT;
                        r_d     = '0;
                    end
                end
            end

            S_COLLECT: begin
                res_tready = 1'b1;
                if (res_tvalid) begin
                    // First beat always loads; later beats only on strictly greater.
                    if (r_q == '0 || res_max > best_max_q) begin
                        best_max_d   = res_max;
                        best_index_d = res_index;
                        best_foa_d   = res_foa;
                    end
                    r_d = r_q + 1'b1;
                    if (r_q == K_LAST) begin
                        state_d = S_DONE;
                    end
                end else if (wd_hit) begin
                    state_d       = S_DONE;
                    timeout_err_d = 1'b1;
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            delta_q       <= '0;
            k_q           <= '0;
            r_q           <= '0;
            n_q           <= '0;
            best_max_q    <= '0;
            best_index_q  <= '0;
            best_foa_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            delta_q       <= delta_d;
            k_q           <= k_d;
            r_q           <= r_d;
            n_q           <= n_d;
            best_max_q    <= best_max_d;
            best_index_q  <= best_index_d;
            best_foa_q    <= best_foa_d;
            timeout_err_q <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_caf_foas_scheduler.sv
// Testbench for caf_foas_scheduler: directed and randomized runs checked against
// a behavioural model of the offset table, sample gating and peak reduction.
module tb_caf_foas_scheduler;

    localparam int PB  = 10;
    localparam int NF  = 3;
    localparam int FB  = 3;
    localparam int LEN = 5;
    localparam int LB  = 3;
    localparam int MB  = 64;
    localparam int TO  = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [PB-1:0] freq_delta;
    logic          busy;
    logic [PB-1:0] freq_step;
    logic          freq_step_valid;
    logic          neg_shift;
    logic          freq_step_ready;
    logic          smp_tvalid;
    logic          smp_tready;
    logic          caf_tvalid;
    logic          caf_tready;
    logic          res_tvalid;
    logic [FB-1:0] res_foa;
    logic [MB-1:0] res_max;
    logic [LB-1:0] res_index;
    logic          res_tready;
    logic [MB-1:0] best_max;
    logic [LB-1:0] best_index;
    logic [FB-1:0] best_foa;
    logic          done;
    logic          timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [MB-1:0] rmax [NF];
    logic [LB-1:0] ridx [NF];
    logic [FB-1:0] rfoa [NF];

    always #5 clk = ~clk;

    caf_foas_scheduler #(
        .phase_bits(PB), .foas(NF), .foas_counter_bits(FB), .length(LEN),
        .length_counter_bits(LB), .out_max_bits(MB), .timeout_cycles(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .freq_delta(freq_delta), .busy(busy),
        .freq_step(freq_step), .freq_step_valid(freq_step_valid), .neg_shift(neg_shift),
        .freq_step_ready(freq_step_ready), .smp_tvalid(smp_tvalid), .smp_tready(smp_tready),
        .caf_tvalid(caf_tvalid), .caf_tready(caf_tready), .res_tvalid(res_tvalid),
        .res_foa(res_foa), .res_max(res_max), .res_index(res_index), .res_tready(res_tready),
        .best_max(best_max), .best_index(best_index), .best_foa(best_foa), .done(done),
        .timeout_err(timeout_err)
    );

    // Offset for slice k is (k - foas/2) * delta; magnitude wraps modulo 2^PB.
    function automatic logic [PB-1:0] exp_step(input int k, input logic [PB-1:0] d);
        longint off;
        longint prod;
        off = longint'(k) - longint'(NF / 2);
        if (off < 0) off = -off;
        prod = off * longint'(d);
        return PB'(prod % (longint'(1) << PB));
    endfunction

    task automatic idle_inputs();
        start = 1'b0; freq_step_ready = 1'b0; smp_tvalid = 1'b0; caf_tready = 1'b0;
        res_tvalid = 1'b0; res_foa = '0; res_max = '0; res_index = '0;
    endtask

    // Starts a run from IDLE and walks the offset table. mode 0: always ready,
    // 1: two stall cycles per offset, 2: random ready.
    task automatic phase_load(input logic [PB-1:0] d, input int mode, input bit hold_start);
        int k = 0;
        int cyc = 0;
        int hold = 0;
        logic exp_neg;
        start = 1'b1;
        freq_delta = d;
        @(posedge clk); @(negedge clk);
        start = hold_start;
        #1;
        n_cmp++;
        if (best_max !== '0 || best_index !== '0 || best_foa !== '0 || timeout_err !== 1'b0) begin
            n_bad++;
            $display("FAIL start_clear: best_max=%0d best_index=%0d best_foa=%0d timeout_err=%0b, expected all 0",
                     best_max, best_index, best_foa, timeout_err);
        end
        while (k < NF && cyc < 100) begin
            freq_delta = PB'($urandom);
            case (mode)
                0: freq_step_ready = 1'b1;
                1: freq_step_ready = (hold == 2);
                default: freq_step_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            exp_neg = (k < NF / 2);
            n_cmp++;
            if (freq_step_valid !== 1'b1 || freq_step !== exp_step(k, d) || neg_shift !== exp_neg
                || smp_tready !== 1'b0 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL load_offset k=%0d: valid=%0b step=%0d neg=%0b busy=%0b, expected valid=1 step=%0d neg=%0b busy=1",
                         k, freq_step_valid, freq_step, neg_shift, busy, exp_step(k, d), exp_neg);
            end
            if (freq_step_ready) begin
                k++;
                hold = 0;
            end else begin
                hold++;
            end
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        freq_step_ready = 1'b0;
        #1;
        n_cmp++;
        if (k != NF || freq_step_valid !== 1'b0 || busy !== 1'b1
            || (mode == 0 && cyc != NF) || (mode == 1 && cyc != 3 * NF)) begin
            n_bad++;
            $display("FAIL load_exit: transfers=%0d cycles=%0d valid=%0b busy=%0b, expected transfers=%0d valid=0 busy=1",
                     k, cyc, freq_step_valid, busy, NF);
        end
    endtask

    // Gates nstop samples with independently toggled valid/ready.
    task automatic phase_stream(input int nstop);
        int n = 0;
        int cyc = 0;
        while (n < nstop && cyc < 400) begin
            smp_tvalid = 1'($urandom_range(0, 1));
            caf_tready = 1'($urandom_range(0, 1));
            #1;
            n_cmp++;
            if (caf_tvalid !== smp_tvalid || smp_tready !== caf_tready || res_tready !== 1'b0) begin
                n_bad++;
                $display("FAIL stream_gate n=%0d: caf_tvalid=%0b smp_tready=%0b res_tready=%0b, expected %0b %0b 0",
                         n, caf_tvalid, smp_tready, res_tready, smp_tvalid, caf_tready);
            end
            if (smp_tvalid && caf_tready) n++;
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        if (n < nstop) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stream_budget: got %0d transfers, expected %0d", n, nstop);
        end
        if (nstop == LEN) begin
            smp_tvalid = 1'b1;
            caf_tready = 1'b1;
            #1;
            n_cmp++;
            if (smp_tready !== 1'b0 || caf_tvalid !== 1'b0 || res_tready !== 1'b1) begin
                n_bad++;
                $display("FAIL stream_exit: smp_tready=%0b caf_tvalid=%0b res_tready=%0b, expected 0 0 1",
                         smp_tready, caf_tvalid, res_tready);
            end
            smp_tvalid = 1'b0;
            caf_tready = 1'b0;
        end
    endtask

    // Delivers rmax/ridx/rfoa with random gaps and checks the reported global peak.
    task automatic phase_collect(input int gap_max);
        int r = 0;
        int cyc = 0;
        logic [MB-1:0] bm;
        logic [LB-1:0] bi;
        logic [FB-1:0] bf;
        while (r < NF && cyc < 500) begin
            res_tvalid = ($urandom_range(0, gap_max) == 0);
            if (res_tvalid) begin
                res_max = rmax[r]; res_index = ridx[r]; res_foa = rfoa[r];
            end else begin
                res_max = {$urandom, $urandom}; res_index = LB'($urandom); res_foa = FB'($urandom);
            end
            #1;
            n_cmp++;
            if (res_tready !== 1'b1 || done !== 1'b0) begin
                n_bad++;
                $display("FAIL collect_ready r=%0d: res_tready=%0b done=%0b, expected 1 0", r, res_tready, done);
            end
            if (res_tvalid) r++;
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        res_tvalid = 1'b0;
        bm = rmax[0]; bi = ridx[0]; bf = rfoa[0];
        for (int i = 1; i < NF; i++) begin
            if (rmax[i] > bm) begin
                bm = rmax[i]; bi = ridx[i]; bf = rfoa[i];
            end
        end
        #1;
        n_cmp++;
        if (done !== 1'b1 || best_max !== bm || best_index !== bi || best_foa !== bf || timeout_err !== 1'b0) begin
            n_bad++;
            $display("FAIL collect_done: done=%0b max=%0d idx=%0d foa=%0d terr=%0b, expected done=1 max=%0d idx=%0d foa=%0d terr=0",
                     done, best_max, best_index, best_foa, timeout_err, bm, bi, bf);
        end
        @(posedge clk); @(negedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || best_max !== bm || best_index !== bi || best_foa !== bf) begin
            n_bad++;
            $display("FAIL done_hold: done=%0b busy=%0b max=%0d idx=%0d foa=%0d, expected done=0 busy=0 max=%0d idx=%0d foa=%0d",
                     done, busy, best_max, best_index, best_foa, bm, bi, bf);
        end
    endtask

    task automatic fill_results(input bit ties);
        for (int i = 0; i < NF; i++) begin
            rmax[i] = ties ? MB'($urandom_range(0, 3)) : {$urandom, $urandom};
            ridx[i] = LB'($urandom_range(0, LEN - 1));
            rfoa[i] = FB'($urandom_range(0, NF - 1));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; smp_tvalid = 1'b1; caf_tready = 1'b1;
        res_tvalid = 1'b1; freq_step_ready = 1'b1; freq_delta = PB'($urandom);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if ({busy, freq_step_valid, neg_shift, smp_tready, caf_tvalid, res_tready, done, timeout_err} !== 8'b0
            || freq_step !== '0 || best_max !== '0 || best_index !== '0 || best_foa !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: busy=%0b fsv=%0b step=%0d smp_tready=%0b caf_tvalid=%0b res_tready=%0b done=%0b best_max=%0d, expected all 0",
                     busy, freq_step_valid, freq_step, smp_tready, caf_tvalid, res_tready, done, best_max);
        end
        idle_inputs();
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_basic_run();
        phase_load(PB'(10), 0, 1'b0);
        phase_stream(LEN);
        rmax[0] = 100; ridx[0] = 2; rfoa[0] = 0;
        rmax[1] = 300; ridx[1] = 4; rfoa[1] = 1;
        rmax[2] = 300; ridx[2] = 1; rfoa[2] = 2;
        phase_collect(0);
    endtask

    task automatic test_load_stall();
        phase_load(PB'(10), 1, 1'b0);
        phase_stream(LEN);
        fill_results(1'b1);
        phase_collect(2);
    endtask

    task automatic test_reset_mid_stream();
        phase_load(PB'($urandom), 2, 1'b0);
        phase_stream(3);
        rst_n = 1'b0; start = 1'b1; smp_tvalid = 1'b1; caf_tready = 1'b1; freq_step_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        #1;
        n_cmp++;
        if ({busy, freq_step_valid, neg_shift, smp_tready, caf_tvalid, res_tready, done, timeout_err} !== 8'b0
            || freq_step !== '0 || best_max !== '0 || best_index !== '0 || best_foa !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_stream: busy=%0b fsv=%0b smp_tready=%0b caf_tvalid=%0b res_tready=%0b best_max=%0d, expected all 0",
                     busy, freq_step_valid, smp_tready, caf_tvalid, res_tready, best_max);
        end
        idle_inputs();
        @(posedge clk); @(negedge clk);
        phase_load(PB'($urandom), 0, 1'b0);
        phase_stream(LEN);
        fill_results(1'b0);
        phase_collect(1);
    endtask

    task automatic test_start_ignored();
        phase_load(PB'($urandom), 2, 1'b1);
        phase_stream(LEN);
        fill_results(1'b1);
        phase_collect(1);
        phase_load(PB'($urandom), 0, 1'b0);
        phase_stream(LEN);
        fill_results(1'b0);
        phase_collect(0);
    endtask

    task automatic test_random_runs();
        for (int i = 0; i < 6; i++) begin
            phase_load(PB'($urandom), 2, 1'($urandom_range(0, 1)));
            phase_stream(LEN);
            start = 1'b0;
            fill_results(1'($urandom_range(0, 1)));
            phase_collect($urandom_range(0, 3));
        end
    endtask

`ifdef CAF_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int idle = 0;
        phase_load(PB'($urandom), 0, 1'b0);
        phase_stream(LEN);
        res_tvalid = 1'b1; res_max = 50; res_index = 3; res_foa = 2;
        @(posedge clk); @(negedge clk);
        res_tvalid = 1'b0;
        while (idle < 100) begin
            #1;
            if (done === 1'b1) break;
            idle++;
            @(posedge clk); @(negedge clk);
        end
        n_cmp++;
        if (idle != TO || timeout_err !== 1'b1 || best_max !== 50 || best_index !== 3 || best_foa !== 2) begin
            n_bad++;
            $display("FAIL timeout_done: idle=%0d terr=%0b max=%0d idx=%0d foa=%0d, expected idle=%0d terr=1 max=50 idx=3 foa=2",
                     idle, timeout_err, best_max, best_index, best_foa, TO);
        end
        @(posedge clk); @(negedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || timeout_err !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_hold: busy=%0b terr=%0b, expected 0 1", busy, timeout_err);
        end
        phase_load(PB'($urandom), 0, 1'b0);
        phase_stream(LEN);
        fill_results(1'b0);
        phase_collect(0);
    endtask
`else
    task automatic test_no_timeout();
        int bad = 0;
        phase_load(PB'($urandom), 0, 1'b0);
        phase_stream(LEN);
        for (int i = 0; i < 3 * TO; i++) begin
            #1;
            if (done !== 1'b0 || busy !== 1'b1 || timeout_err !== 1'b0 || res_tready !== 1'b1) bad++;
            @(posedge clk); @(negedge clk);
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL no_timeout_wait: %0d bad cycles, expected 0", bad);
        end
        fill_results(1'b0);
        phase_collect(0);
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation did not finish, expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        freq_delta = '0;
        @(negedge clk);
        test_reset();
        test_basic_run();
        test_load_stall();
        test_reset_mid_stream();
        test_start_ignored();
`ifdef CAF_SCHED_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random_runs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
